// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module   : seq_pattern_tx
// Brief    : Serial pattern transmitter (1..8 bits, 1..16 frames, idle gaps).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_pattern,
  input  logic [2:0] i_len,
  input  logic [3:0] i_reps,
  input  logic [3:0] i_gap,
  output logic       o_ser_out,
  output logic       o_ser_valid,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [7:0] r_pat,     w_pat_nxt;
  logic [2:0] r_len,     w_len_nxt;
  logic [3:0] r_gap,     w_gap_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0] r_frm_cnt, w_frm_cnt_nxt;
  logic [3:0] r_gap_cnt, w_gap_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pat     <= 8'd0;
      r_len     <= 3'd0;
      r_gap     <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_frm_cnt <= 4'd0;
      r_gap_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_len     <= w_len_nxt;
      r_gap     <= w_gap_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_frm_cnt <= w_frm_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_len_nxt     = r_len;
    w_gap_nxt     = r_gap;
    w_bit_cnt_nxt = r_bit_cnt;
    w_frm_cnt_nxt = r_frm_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pat_nxt     = i_pattern;
          w_len_nxt     = i_len;
          w_gap_nxt     = i_gap;
          w_bit_cnt_nxt = i_len;
          w_frm_cnt_nxt = i_reps;
          w_gap_cnt_nxt = 4'd0;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt != 3'd0) begin
          w_bit_cnt_nxt = r_bit_cnt - 3'd1;
        end else if (r_frm_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else if (r_gap == 4'd0) begin
          // Back-to-back frame: reload without leaving SHIFT
          w_bit_cnt_nxt = r_len;
          w_frm_cnt_nxt = r_frm_cnt - 4'd1;
        end else begin
          w_gap_cnt_nxt = r_gap - 4'd1;
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt != 4'd0) begin
          w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        end else begin
          w_bit_cnt_nxt = r_len;
          w_frm_cnt_nxt = r_frm_cnt - 4'd1;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode registered state only
  assign o_ser_valid = (r_state == S_SHIFT);
  assign o_ser_out   = (r_state == S_SHIFT) & r_pat[r_bit_cnt];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
// Module   : tb_seq_pattern_tx
// Brief    : Self-checking bench for seq_pattern_tx against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic [7:0] i_pattern;
  logic [2:0] i_len;
  logic [3:0] i_reps;
  logic [3:0] i_gap;
  logic       o_ser_out;
  logic       o_ser_valid;
  logic       o_busy;
  logic       o_done;

  seq_pattern_tx u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_pattern  (i_pattern),
    .i_len      (i_len),
    .i_reps     (i_reps),
    .i_gap      (i_gap),
    .o_ser_out  (o_ser_out),
    .o_ser_valid(o_ser_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic o;
    logic d;
  } item_t;

  item_t q[$];
  int    n_chk    = 0;
  int    n_fail   = 0;
  int    busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole transaction expanded up front: one entry per busy cycle
  task automatic load_model(input logic [7:0] pat, input int len, input int reps, input int gap);
    for (int f = 0; f <= reps; f++) begin
      for (int b = len; b >= 0; b--) q.push_back('{v: 1'b1, o: pat[b], d: 1'b0});
      if (f != reps)
        for (int g = 0; g < gap; g++) q.push_back('{v: 1'b0, o: 1'b0, d: 1'b0});
    end
    q.push_back('{v: 1'b0, o: 1'b0, d: 1'b1});
  endtask

  task automatic model_edge();
    if (rst) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (i_start) load_model(i_pattern, int'(i_len), int'(i_reps), int'(i_gap));
  endtask

  task automatic step();
    item_t e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = (q.size() != 0) ? q[0] : '{v: 1'b0, o: 1'b0, d: 1'b0};
    chk("ser_valid", o_ser_valid, e.v);
    chk("ser_out",   o_ser_out,   e.o);
    chk("done",      o_done,      e.d);
    chk("busy",      o_busy,      (q.size() != 0));
    if (o_busy) busy_cnt++;
  endtask

  task automatic fire(input logic [7:0] pat, input logic [2:0] len,
                      input logic [3:0] reps, input logic [3:0] gap);
    i_pattern = pat; i_len = len; i_reps = reps; i_gap = gap;
    i_start = 1'b1;
    busy_cnt = 0;
    step();
    i_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_pattern = 8'd0; i_len = 3'd0; i_reps = 4'd0; i_gap = 4'd0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // 3-bit single frame
    fire(8'h05, 3'd2, 4'd0, 4'd0); idle(6);
    chk("busy_cnt_3bit", busy_cnt, 4);

    // Two frames separated by two idle cycles
    fire(8'h05, 3'd2, 4'd1, 4'd2); idle(12);
    chk("busy_cnt_gap", busy_cnt, 9);

    // Three back-to-back 8-bit frames
    fire(8'hA5, 3'd7, 4'd2, 4'd0); idle(28);
    chk("busy_cnt_b2b", busy_cnt, 25);

    // Single-bit frame
    fire(8'h01, 3'd0, 4'd0, 4'd0); idle(4);
    chk("busy_cnt_1bit", busy_cnt, 2);

    // Start held and inputs churned while busy, then held through DONE
    i_pattern = 8'hC3; i_len = 3'd5; i_reps = 4'd1; i_gap = 4'd1; i_start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      i_pattern = 8'($urandom); i_len = 3'($urandom); i_reps = 4'($urandom_range(0, 1));
      i_gap = 4'($urandom_range(0, 2));
    end
    i_start = 1'b0;
    idle(40);

    // Reset on the 2nd bit of an 8-bit frame, then a clean restart
    fire(8'h96, 3'd7, 4'd0, 4'd0);
    step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    fire(8'h96, 3'd7, 4'd0, 4'd0); idle(10);
    chk("busy_cnt_after_rst", busy_cnt, 9);

    // Random traffic with rare resets
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      i_start   = ($urandom_range(0, 3) == 0);
      i_pattern = 8'($urandom);
      i_len     = 3'($urandom);
      i_reps    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      i_gap     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      step();
    end
    rst = 1'b0; i_start = 1'b0;
    idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter: none; pattern width fixed at 8 bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to transmit; sampled only in IDLE.
REQ-005 pattern  input  8  bits to send; the active bits are right-aligned, sent MSB-of-active-field first.
REQ-006 len  input  3  pattern length minus one (0..7 -> 1..8 bits).
REQ-007 reps  input  4  repetition count minus one (0..15 -> 1..16 frames).
REQ-008 gap  input  4  idle cycles between consecutive frames (0..15).
REQ-009 ser_out  output  1  serial bit; 0 whenever ser_valid=0.
REQ-010 ser_valid  output  1  high exactly on cycles carrying a pattern bit.
REQ-011 busy  output  1  high from the cycle after start is accepted until done, inclusive.
REQ-012 done  output  1  single-cycle pulse after the last bit of the last frame.

Function
REQ-013 Moore FSM; ser_out, ser_valid, busy and done SHALL be functions of registered state only (no combinational path from any input).
REQ-014 States: IDLE, SHIFT, GAP, DONE; 2-bit encoding; illegal encodings SHALL go to IDLE next cycle.
REQ-015 IDLE: start=1 -> capture pattern/len/reps/gap into shadow registers, load bit counter = len, frame counter = reps, go to SHIFT; start=0 -> stay.
REQ-016 Input changes after acceptance SHALL NOT affect the frame in progress.
REQ-017 SHIFT: ser_valid=1, ser_out = pattern_shadow[bit counter]; bit counter decrements each cycle.
REQ-018 SHIFT with bit counter=0 and frame counter=0 -> DONE.
REQ-019 SHIFT with bit counter=0, frame counter>0, gap=0 -> reload bit counter, decrement frame counter, stay in SHIFT (back-to-back frames, no idle cycle).
REQ-020 SHIFT with bit counter=0, frame counter>0, gap>0 -> GAP; gap counter loaded with gap-1.
REQ-021 GAP: ser_valid=0, ser_out=0; gap counter decrements; at 0 -> reload bit counter, decrement frame counter, go to SHIFT. Exactly gap idle cycles between frames.
REQ-022 DONE: done=1, busy=1, ser_valid=0 for exactly one cycle, then IDLE unconditionally.
REQ-023 start while busy=1 SHALL be ignored (not queued); start held high through DONE is accepted in the following IDLE cycle.
REQ-024 Latency: first bit on the cycle after the start-sampling edge; total busy cycles = (len+1)*(reps+1) + gap*reps + 1.
REQ-025 Counters SHALL never wrap; all arithmetic is unsigned at the declared widths.

Reset
REQ-026 rst=1 at a rising edge -> state IDLE, all counters and shadow registers 0; ser_out=0, ser_valid=0, busy=0, done=0 from the next cycle.
REQ-027 rst SHALL take priority over start and over any in-progress frame; a reset mid-frame truncates output immediately with no done pulse.
REQ-028 First cycle after rst deasserts SHALL be IDLE, able to accept start.

Verification
REQ-029 pattern=8'h05, len=2, reps=0, gap=0, start pulse -> ser_out 1,0,1 on cycles 1-3 with ser_valid=1; done on cycle 4; busy cycles 1-4.
REQ-030 pattern=8'h05, len=2, reps=1, gap=2 -> 1,0,1, two idle cycles (valid=0, out=0), 1,0,1, done; 9 busy cycles total.
REQ-031 pattern=8'hA5, len=7, reps=2, gap=0 -> 24 contiguous valid bits 10100101 x3; done on cycle 25.
REQ-032 len=0, pattern bit0=1, reps=0 -> single valid 1 on cycle 1; done on cycle 2.
REQ-033 start re-pulsed and pattern changed mid-frame -> output unchanged, no restart; start held through DONE -> new frame begins 1 cycle after IDLE.
REQ-034 rst asserted on the 2nd bit of an 8-bit frame -> next cycle all outputs 0, no done; fresh start afterwards sends the full pattern correctly.
